// File: rtl/jtcps1_tilemap_render_if.sv
// Memory and line-buffer bus between the CPS1 scroll-layer line renderer and
// its VRAM, graphics ROM and layer line buffer.
interface jtcps1_tilemap_render_if;
  logic [23:0] vram_addr;
  logic [15:0] vram_data;
  logic        vram_ok;
  logic        vram_cs;
  logic [21:0] rom_addr;
  logic [15:0] rom_data;
  logic        rom_ok;
  logic        rom_cs;
  logic [8:0]  buf_addr;
  logic [8:0]  buf_data;
  logic        buf_wr;

  modport master (
    output vram_addr, vram_cs,
    input  vram_data, vram_ok,
    output rom_addr, rom_cs,
    input  rom_data, rom_ok,
    output buf_addr, buf_data, buf_wr
  );

  modport slave (
    input  vram_addr, vram_cs,
    output vram_data, vram_ok,
    input  rom_addr, rom_cs,
    output rom_data, rom_ok,
    input  buf_addr, buf_data, buf_wr
  );
endinterface

// File: rtl/jtcps1_tilemap_render.sv
// CPS1 scroll-layer line renderer: walks one scan line of SIZE x SIZE tiles
// through VRAM and graphics ROM into the layer line buffer.
// Define JTCPS1_ROWSCROLL_EN to add the per-line row-scroll fetch.
module jtcps1_tilemap_render #(
  parameter int SIZE  = 8,
  parameter int LINEW = 384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  v,
  input  logic [15:0] vram_base,
  input  logic [15:0] hpos,
  input  logic [15:0] vpos,
  input  logic [15:0] rowscr_base,
  input  logic        start,
  output logic        done,
  jtcps1_tilemap_render_if.master bus
);

  localparam int SB  = $clog2(SIZE);
  localparam int WB  = SB - 2;
  localparam int WPT = SIZE / 4;
  localparam logic [10:0] MAP_MASK = 11'((1 << (SB + 6)) - 1);
  localparam logic [10:0] LINE_END = 11'(LINEW);

  if (SIZE != 8 && SIZE != 16 && SIZE != 32) begin : g_bad_size
    $error("jtcps1_tilemap_render: SIZE must be 8, 16 or 32");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROWSCR,
    ST_MAP_CODE,
    ST_MAP_ATTR,
    ST_ROM_REQ,
    ST_DRAW,
    ST_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [8:0]    v_q, v_d;
  logic [15:0]   vbase_q, vbase_d;
  logic [15:0]   hpos_q, hpos_d;
  logic [10:0]   vn_q, vn_d;
  logic [10:0]   hn_q, hn_d;
  logic [11:0]   x_q, x_d;        // two's-complement screen cursor
  logic [15:0]   code_q, code_d;
  logic [6:0]    attr_q, attr_d;
  logic [15:0]   word_q, word_d;
  logic [1:0]    pix_q, pix_d;
  logic [WB-1:0] widx_q, widx_d;
  logic          done_q, done_d;

  function automatic logic [10:0] origin_hn(input logic [15:0] h);
    return 11'(h & ~16'(SIZE - 1)) & MAP_MASK;
  endfunction

  function automatic logic [11:0] origin_x(input logic [15:0] h);
    return 12'd0 - 12'(h & 16'(SIZE - 1));
  endfunction

  logic [5:0]    col, row;
  logic [11:0]   scan;
  logic [23:0]   map_addr;
  logic [SB-1:0] trow;
  logic [WB-1:0] widx_rom;
  logic [3:0]    pixel;
  logic [11:0]   x_nx;
  logic [15:0]   hsum;
  logic          hflip, vflip, on_line, line_end;

  assign hflip    = attr_q[5];
  assign vflip    = attr_q[6];
  assign col      = 6'(hn_q >> SB);
  assign row      = 6'(vn_q >> SB);
  assign scan     = {row[5], col, row[4:0]};
  assign map_addr = {vbase_q, 8'd0} + {11'd0, scan, 1'b0};
  assign trow     = vflip ? ~vn_q[SB-1:0] : vn_q[SB-1:0];
  assign widx_rom = hflip ? WB'(WPT - 1) - widx_q : widx_q;
  // Pixel planes are interleaved one bit per nibble; hflip walks the word from the top.
  assign pixel    = hflip ? {word_q[15], word_q[11], word_q[7], word_q[3]}
                          : {word_q[12], word_q[8],  word_q[4], word_q[0]};
  assign x_nx     = x_q + 12'd1;
  assign on_line  = !x_q[11] && (x_q[10:0] < LINE_END);
  assign line_end = !x_nx[11] && (x_nx[10:0] >= LINE_END);
  assign hsum     = hpos_q + bus.vram_data;
  assign done     = done_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      v_q     <= '0;
      vbase_q <= '0;
      hpos_q  <= '0;
      vn_q    <= '0;
      hn_q    <= '0;
      x_q     <= '0;
      code_q  <= '0;
      attr_q  <= '0;
      word_q  <= '0;
      pix_q   <= '0;
      widx_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      vbase_q <= vbase_d;
      hpos_q  <= hpos_d;
      vn_q    <= vn_d;
      hn_q    <= hn_d;
      x_q     <= x_d;
      code_q  <= code_d;
      attr_q  <= attr_d;
      word_q  <= word_d;
      pix_q   <= pix_d;
      widx_q  <= widx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    v_d           = v_q;
    vbase_d       = vbase_q;
    hpos_d        = hpos_q;
    vn_d          = vn_q;
    hn_d          = hn_q;
    x_d           = x_q;
    code_d        = code_q;
    attr_d        = attr_q;
    word_d        = word_q;
    pix_d         = pix_q;
    widx_d        = widx_q;
    done_d        = done_q;
    bus.vram_cs   = 1'b0;
    bus.vram_addr = '0;
    bus.rom_cs    = 1'b0;
    bus.rom_addr  = '0;
    bus.buf_wr    = 1'b0;
    bus.buf_addr  = '0;
    bus.buf_data  = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          v_d     = v;
          vbase_d = vram_base;
          hpos_d  = hpos;
          vn_d    = 11'(vpos + {7'd0, v}) & MAP_MASK;
          hn_d    = origin_hn(hpos);
          x_d     = origin_x(hpos);
`ifdef JTCPS1_ROWSCROLL_EN
          state_d = ST_ROWSCR;
`else
          state_d = ST_MAP_CODE;
`endif
        end
      end

      ST_ROWSCR: begin
        bus.vram_cs   = 1'b1;
        bus.vram_addr = {rowscr_base, 8'd0} + {15'd0, v_q};
        if (bus.vram_ok) begin
          hpos_d  = hsum;
          hn_d    = origin_hn(hsum);
          x_d     = origin_x(hsum);
          state_d = ST_MAP_CODE;
        end
      end

      ST_MAP_CODE: begin
        bus.vram_cs   = 1'b1;
        bus.vram_addr = map_addr;
        if (bus.vram_ok) begin
          code_d  = bus.vram_data;
          state_d = ST_MAP_ATTR;
        end
      end

      ST_MAP_ATTR: begin
        bus.vram_cs   = 1'b1;
        bus.vram_addr = map_addr + 24'd1;
        if (bus.vram_ok) begin
          attr_d  = bus.vram_data[6:0];
          widx_d  = '0;
          state_d = ST_ROM_REQ;
        end
      end

      ST_ROM_REQ: begin
        bus.rom_cs   = 1'b1;
        bus.rom_addr = 22'({code_q, trow, widx_rom});
        if (bus.rom_ok) begin
          word_d  = bus.rom_data;
          pix_d   = '0;
          state_d = ST_DRAW;
        end
      end

      ST_DRAW: begin
        bus.buf_addr = x_q[8:0];
        bus.buf_data = {attr_q[4:0], pixel};
        bus.buf_wr   = on_line && (pixel != 4'hF);
        word_d       = hflip ? (word_q << 1) : (word_q >> 1);
        x_d          = x_nx;
        pix_d        = pix_q + 2'd1;
        if (pix_q == 2'd3) begin
          if (line_end) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else if (widx_q == WB'(WPT - 1)) begin
            hn_d    = (hn_q + 11'(SIZE)) & MAP_MASK;
            state_d = ST_MAP_CODE;
          end else begin
            widx_d  = widx_q + WB'(1);
            state_d = ST_ROM_REQ;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jtcps1_tilemap_render.sv
// Randomised line-render bench for jtcps1_tilemap_render with a pixel-level
// reference model derived from the map/tile/ROM addressing rules.
module tb_jtcps1_tilemap_render;
  localparam int SIZE  = 8;
  localparam int LINEW = 384;

  logic        clk, rst, start, done;
  logic [8:0]  v_in;
  logic [15:0] vbase_in, hpos_in, vpos_in, rbase_in;

  jtcps1_tilemap_render_if bus ();

  jtcps1_tilemap_render #(.SIZE(SIZE), .LINEW(LINEW)) dut (
    .clk        (clk),
    .rst        (rst),
    .v          (v_in),
    .vram_base  (vbase_in),
    .hpos       (hpos_in),
    .vpos       (vpos_in),
    .rowscr_base(rbase_in),
    .start      (start),
    .done       (done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] seed;

  int          vdelay = 0;
  bit          rom_rand = 0;
  int          vcnt = 0;
  bit          v_pend = 0, r_pend = 0;
  logic [23:0] v_prev;
  logic [21:0] r_prev;
  int          stab_err = 0;

  int          wcnt [LINEW];
  logic [8:0]  wdat [LINEW];
  int          wr_total = 0;
  int          oob = 0;
  bit          exp_op  [LINEW];
  logic [8:0]  exp_dat [LINEW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mix(input logic [31:0] a);
    logic [31:0] z;
    z = a ^ seed;
    z = z * 32'h9E3779B1;
    z = z ^ (z >> 15);
    z = z * 32'h85EBCA6B;
    z = z ^ (z >> 13);
    return z;
  endfunction

  function automatic logic [15:0] vram_word(input logic [23:0] a);
    logic [31:0] z;
    z = mix({8'h5A, a});
    return z[15:0];
  endfunction

  function automatic logic [15:0] rom_word(input logic [21:0] a);
    logic [31:0] z;
    z = mix({10'h2C3, a});
    if (z[18:16] == 3'd0) return 16'hFFFF;
    return z[15:0];
  endfunction

  // VRAM responder: fixed wait of vdelay cycles; also watches request stability.
  always @(negedge clk) begin
    if (v_pend && (!bus.vram_cs || bus.vram_addr !== v_prev)) stab_err++;
    if (bus.vram_cs && vcnt >= vdelay) begin
      bus.vram_ok   = 1'b1;
      bus.vram_data = vram_word(bus.vram_addr);
      vcnt          = 0;
    end else begin
      bus.vram_ok   = 1'b0;
      bus.vram_data = 16'($urandom);
      vcnt          = bus.vram_cs ? vcnt + 1 : 0;
    end
    v_pend = bus.vram_cs && !bus.vram_ok && !rst;
    v_prev = bus.vram_addr;
  end

  // ROM responder: zero-wait or randomly toggled ok.
  always @(negedge clk) begin
    if (r_pend && (!bus.rom_cs || bus.rom_addr !== r_prev)) stab_err++;
    if (bus.rom_cs && (!rom_rand || $urandom_range(0, 1) == 1)) begin
      bus.rom_ok   = 1'b1;
      bus.rom_data = rom_word(bus.rom_addr);
    end else begin
      bus.rom_ok   = 1'b0;
      bus.rom_data = 16'($urandom);
    end
    r_pend = bus.rom_cs && !bus.rom_ok && !rst;
    r_prev = bus.rom_addr;
  end

  always @(negedge clk) begin
    if (bus.buf_wr) begin
      wr_total++;
      if (int'(bus.buf_addr) >= LINEW) oob++;
      else begin
        wcnt[bus.buf_addr]++;
        wdat[bus.buf_addr] = bus.buf_data;
      end
    end
  end

  task automatic clear_capture();
    for (int i = 0; i < LINEW; i++) begin
      wcnt[i] = 0;
      wdat[i] = '0;
    end
    wr_total = 0;
    oob      = 0;
    stab_err = 0;
  endtask

  // Screen pixel x shows map pixel (hpos + x) of line (vpos + v), both wrapping on the map size.
  task automatic build_model();
    int mapw, vn, heff, h, col, px, row, scan, tcol, trow, wsel, k;
    logic [23:0] maddr;
    logic [15:0] code, attr, w;
    logic [21:0] ra;
    logic [3:0]  p;
    mapw = 64 * SIZE;
    vn   = (int'(vpos_in) + int'(v_in)) % mapw;
    heff = int'(hpos_in);
`ifdef JTCPS1_ROWSCROLL_EN
    heff = (heff + int'(vram_word({rbase_in, 8'd0} + 24'(v_in)))) % 65536;
`endif
    row = vn / SIZE;
    for (int x = 0; x < LINEW; x++) begin
      h     = (heff + x) % mapw;
      col   = h / SIZE;
      px    = h % SIZE;
      scan  = (row / 32) * 2048 + col * 32 + (row % 32);
      maddr = {vbase_in, 8'd0} + 24'(scan * 2);
      code  = vram_word(maddr);
      attr  = vram_word(maddr + 24'd1);
      trow  = attr[6] ? SIZE - 1 - (vn % SIZE) : vn % SIZE;
      tcol  = attr[5] ? SIZE - 1 - px : px;
      wsel  = tcol / 4;
      k     = tcol % 4;
      ra    = 22'((int'(code) * SIZE + trow) * (SIZE / 4) + wsel);
      w     = rom_word(ra);
      p     = {w[12 + k], w[8 + k], w[4 + k], w[k]};
      exp_op[x]  = (p != 4'hF);
      exp_dat[x] = {attr[4:0], p};
    end
  endtask

  task automatic run_line(input string tag, input logic [8:0] lv, input logic [15:0] hp,
                          input logic [15:0] vp, input logic [15:0] base,
                          input logic [15:0] rbase, input int vdel, input bit rrand);
    int nbad, nexp, first;
    @(negedge clk);
    v_in     = lv;
    hpos_in  = hp;
    vpos_in  = vp;
    vbase_in = base;
    rbase_in = rbase;
    vdelay   = vdel;
    rom_rand = rrand;
    clear_capture();
    build_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    nbad  = 0;
    nexp  = 0;
    first = -1;
    for (int x = 0; x < LINEW; x++) begin
      if (exp_op[x]) nexp++;
      if (exp_op[x] ? (wcnt[x] != 1 || wdat[x] !== exp_dat[x]) : (wcnt[x] != 0)) begin
        nbad++;
        if (first < 0) first = x;
      end
    end
    if (first >= 0)
      $display("  %s first bad x=%0d writes=%0d data=0x%0h want_write=%0d want_data=0x%0h",
               tag, first, wcnt[first], wdat[first], exp_op[first], exp_dat[first]);
    check({tag, "_pixels"}, 32'(nbad), 32'd0);
    check({tag, "_writes"}, 32'(wr_total), 32'(nexp));
    check({tag, "_oob"}, 32'(oob), 32'd0);
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    seed     = $urandom;
    rst      = 1'b1;
    start    = 1'b0;
    v_in     = '0;
    vbase_in = '0;
    hpos_in  = '0;
    vpos_in  = '0;
    rbase_in = '0;
    repeat (3) @(negedge clk);
    check("rst_done",      32'(done),          32'd0);
    check("rst_vram_cs",   32'(bus.vram_cs),   32'd0);
    check("rst_rom_cs",    32'(bus.rom_cs),    32'd0);
    check("rst_buf_wr",    32'(bus.buf_wr),    32'd0);
    check("rst_vram_addr", 32'(bus.vram_addr), 32'd0);
    check("rst_rom_addr",  32'(bus.rom_addr),  32'd0);
    check("rst_buf_addr",  32'(bus.buf_addr),  32'd0);
    check("rst_buf_data",  32'(bus.buf_data),  32'd0);
    rst = 1'b0;

    run_line("basic", 9'd0, 16'd0, 16'd0, 16'h0040, 16'h0900, 0, 1'b0);
    repeat (5) @(negedge clk);
    check("done_held", 32'(done), 32'd1);
    run_line("hpos5", 9'd0, 16'd5, 16'd0, 16'h0040, 16'h0900, 0, 1'b0);
    run_line("hwrap", 9'd17, 16'h01F3, 16'h0123, 16'h0A00, 16'h0900, 0, 1'b0);
    run_line("vwrap", 9'd250, 16'h8101, 16'h01F0, 16'h0310, 16'h0900, 0, 1'b0);
    run_line("vram_wait", 9'd100, 16'h0077, 16'h0045, 16'h0200, 16'h0901, 5, 1'b0);
    run_line("rom_rand", 9'd100, 16'h0077, 16'h0045, 16'h0200, 16'h0901, 0, 1'b1);
    run_line("both_wait", 9'd100, 16'h0077, 16'h0045, 16'h0200, 16'h0901, 5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_line($sformatf("rand%0d", i), 9'($urandom), 16'($urandom), 16'($urandom),
               16'($urandom), 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a line: strobes drop at once and nothing is written afterwards.
    @(negedge clk);
    hpos_in = 16'h0013;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (150) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_vram_cs", 32'(bus.vram_cs), 32'd0);
    check("midrst_rom_cs",  32'(bus.rom_cs),  32'd0);
    check("midrst_buf_wr",  32'(bus.buf_wr),  32'd0);
    @(posedge clk);
    #1;
    check("midrst_next_strobes", 32'({bus.vram_cs, bus.rom_cs, bus.buf_wr}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_capture();
    repeat (40) @(negedge clk);
    check("midrst_no_writes", 32'(wr_total), 32'd0);
    check("midrst_done", 32'(done), 32'd0);

    run_line("post_rst", 9'd33, 16'h0102, 16'h0007, 16'h0040, 16'h0900, 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
